// File: rtl/button_debouncer_multi.sv
// N-channel button debouncer: 2-FF sync, shared tick prescaler, per-channel stability counter, level + press/release pulses.
// Latency: 2 cycles sync plus STABLE_TICKS tick boundaries; pulses are registered and coincide with the new level.
// No backpressure; optional auto-repeat of pressed pulses is built only when BTN_AUTOREPEAT_EN is defined.
module button_debouncer_multi #(
    parameter int NUM_BTNS      = 4,
    parameter int ACTIVE_LOW    = 1,
    parameter int TICK_DIV      = 50000,
    parameter int STABLE_TICKS  = 20,
    parameter int REPEAT_DELAY  = 500,
    parameter int REPEAT_PERIOD = 100
) (
    input  logic                CLOCK_50,
    input  logic                resetn,
    input  logic [NUM_BTNS-1:0] button,
    output logic [NUM_BTNS-1:0] level,
    output logic [NUM_BTNS-1:0] pressed,
    output logic [NUM_BTNS-1:0] released,
    output logic                tick
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam int CW = $clog2(STABLE_TICKS + 1);
    localparam logic [PW-1:0] TICK_LAST   = PW'(TICK_DIV - 1);
    localparam logic [CW-1:0] STABLE_LAST = CW'(STABLE_TICKS - 1);

    if (NUM_BTNS < 1 || NUM_BTNS > 16 || TICK_DIV < 1 || STABLE_TICKS < 1 ||
        REPEAT_DELAY < 1 || REPEAT_PERIOD < 1) begin : g_bad_cfg
        $error("button_debouncer_multi: illegal parameter set");
    end

    logic [PW-1:0]       div_q, div_d;
    logic                tick_q, tick_d;
    logic [NUM_BTNS-1:0] sync1_q, sync2_q, raw_act;
    logic [NUM_BTNS-1:0] level_q, level_d;
    logic [NUM_BTNS-1:0] pressed_q, pressed_d;
    logic [NUM_BTNS-1:0] released_q, released_d;
    logic [NUM_BTNS-1:0] flip;
    logic [NUM_BTNS-1:0] rpt_fire;
    logic [CW-1:0]       cnt_q [NUM_BTNS];
    logic [CW-1:0]       cnt_d [NUM_BTNS];

    assign raw_act = (ACTIVE_LOW != 0) ? ~button : button;

    // tick_q is registered so it is high in exactly the cycle the divider holds TICK_DIV-1
    always_comb begin
        div_d  = (div_q == TICK_LAST) ? '0 : div_q + PW'(1);
        tick_d = (div_d == TICK_LAST);
    end

    always_comb begin
        level_d = level_q;
        flip    = '0;
        for (int i = 0; i < NUM_BTNS; i++) begin
            cnt_d[i] = cnt_q[i];
            if (tick_q) begin
                if (sync2_q[i] == level_q[i]) begin
                    cnt_d[i] = '0;
                end else if (cnt_q[i] == STABLE_LAST) begin
                    cnt_d[i]   = '0;
                    level_d[i] = sync2_q[i];
                    flip[i]    = 1'b1;
                end else begin
                    cnt_d[i] = cnt_q[i] + CW'(1);
                end
            end
        end
        pressed_d  = (flip & sync2_q) | rpt_fire;
        released_d = flip & ~sync2_q;
    end

`ifdef BTN_AUTOREPEAT_EN
    localparam int RPT_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
    localparam int RW      = $clog2(RPT_MAX + 1);
    localparam logic [RW-1:0] DLY_LAST = RW'(REPEAT_DELAY - 1);
    localparam logic [RW-1:0] PER_LAST = RW'(REPEAT_PERIOD - 1);

    logic [RW-1:0]       rpt_q [NUM_BTNS];
    logic [RW-1:0]       rpt_d [NUM_BTNS];
    logic [NUM_BTNS-1:0] armed_q, armed_d;

    // counter holds zero while released, so it is already clear at the press pulse;
    // the tick that debounces a release never produces a repeat
    always_comb begin
        armed_d  = armed_q;
        rpt_fire = '0;
        for (int i = 0; i < NUM_BTNS; i++) begin
            rpt_d[i] = rpt_q[i];
            if (!level_q[i]) begin
                rpt_d[i]   = '0;
                armed_d[i] = 1'b0;
            end else if (tick_q && !flip[i]) begin
                if (rpt_q[i] == (armed_q[i] ? PER_LAST : DLY_LAST)) begin
                    rpt_d[i]    = '0;
                    armed_d[i]  = 1'b1;
                    rpt_fire[i] = 1'b1;
                end else begin
                    rpt_d[i] = rpt_q[i] + RW'(1);
                end
            end
        end
    end

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            armed_q <= '0;
            for (int i = 0; i < NUM_BTNS; i++) rpt_q[i] <= '0;
        end else begin
            armed_q <= armed_d;
            for (int i = 0; i < NUM_BTNS; i++) rpt_q[i] <= rpt_d[i];
        end
    end
`else
    assign rpt_fire = '0;
`endif

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            div_q      <= '0;
            tick_q     <= 1'b0;
            sync1_q    <= '0;
            sync2_q    <= '0;
            level_q    <= '0;
            pressed_q  <= '0;
            released_q <= '0;
            for (int i = 0; i < NUM_BTNS; i++) cnt_q[i] <= '0;
        end else begin
            div_q      <= div_d;
            tick_q     <= tick_d;
            sync1_q    <= raw_act;
            sync2_q    <= sync1_q;
            level_q    <= level_d;
            pressed_q  <= pressed_d;
            released_q <= released_d;
            for (int i = 0; i < NUM_BTNS; i++) cnt_q[i] <= cnt_d[i];
        end
    end

    assign level    = level_q;
    assign pressed  = pressed_q;
    assign released = released_q;
    assign tick     = tick_q;

endmodule
